// File: rtl/star_pixel_gen.sv
// Pixel-colour stage: renders a triangular player ship over a scrolling starfield
// and moves the ship only on frame boundaries, with syncs delayed to match the RGB.
module star_pixel_gen #(
  parameter int          SHIP_W   = 16,
  parameter int          SHIP_H   = 16,
  parameter int          H_VIS    = 640,
  parameter int          V_VIS    = 480,
  parameter logic [11:0] SHIP_RGB = 12'hFF0,
  parameter logic [11:0] STAR_RGB = 12'hFFF,
  parameter logic [11:0] BG_RGB   = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_clock,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        video_on,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        pos_valid,
  output logic        pos_ready,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_tick
);

  localparam logic [9:0] X_MAX = 10'(H_VIS - SHIP_W);
  localparam logic [9:0] Y_MAX = 10'(V_VIS - SHIP_H);
  localparam logic [9:0] SHIP_X_RST = 10'd312;
  localparam logic [9:0] SHIP_Y_RST = 10'd440;

  localparam logic signed [10:0] SW_S   = 11'(SHIP_W);
  localparam logic signed [10:0] SH_S   = 11'(SHIP_H);
  localparam logic signed [10:0] APEX_L = 11'(SHIP_W / 2 - 1);
  localparam logic signed [10:0] APEX_R = 11'(SHIP_W / 2);

  // Saturate a requested coordinate to the last legal ship position.
  function automatic logic [9:0] sat_pos(input logic [9:0] v, input logic [9:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // Triangle, apex up: the lit span widens by one pixel each side every two rows.
  function automatic logic ship_lit(input logic [9:0] sx, input logic [9:0] sy,
                                    input logic [9:0] ox, input logic [9:0] oy);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic signed [10:0] half;
    dx   = $signed({1'b0, sx}) - $signed({1'b0, ox});
    dy   = $signed({1'b0, sy}) - $signed({1'b0, oy});
    half = dy >>> 1;
    return (dx >= 11'sd0) && (dx < SW_S) && (dy >= 11'sd0) && (dy < SH_S) &&
           (dx >= APEX_L - half) && (dx <= APEX_R + half);
  endfunction

  function automatic logic star_lit(input logic [9:0] sx, input logic [9:0] sy,
                                    input logic [9:0] scr);
    logic [9:0] ry;
    ry = sy - scr;
    return ((sx[4:0] ^ ry[4:0]) == 5'b10101) && (sx[5] == ry[6]);
  endfunction

  logic        p_clock_d;
  logic        tick;
  logic        boundary;
  logic        accept;

  logic [9:0]  x_p1;
  logic [9:0]  y_p1;
  logic        vld_p1;
  logic        hs_p1;
  logic        vs_p1;

  logic [11:0] rgb_p2;
  logic        hs_p2;
  logic        vs_p2;
  logic        frame_tick_r;

  logic [9:0]  scroll;
  logic        pending;
  logic [9:0]  pend_x;
  logic [9:0]  pend_y;
  logic [9:0]  ship_x;
  logic [9:0]  ship_y;
  logic [11:0] pix_rgb;

  assign tick     = p_clock & ~p_clock_d;
  assign boundary = tick & vsync & ~vs_p1;
  assign accept   = pos_valid & ~pending;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) p_clock_d <= 1'b0;
    else       p_clock_d <= p_clock;
  end

  // Stage 1: capture the incoming pixel coordinate and timing signals.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_p1   <= '0;
      y_p1   <= '0;
      vld_p1 <= 1'b0;
      hs_p1  <= 1'b0;
      vs_p1  <= 1'b0;
    end else if (tick) begin
      x_p1   <= x;
      y_p1   <= y;
      vld_p1 <= video_on;
      hs_p1  <= hsync;
      vs_p1  <= vsync;
    end
  end

  always_comb begin
    pix_rgb = BG_RGB;
    if (!vld_p1)                                  pix_rgb = 12'h000;
    else if (ship_lit(x_p1, y_p1, ship_x, ship_y)) pix_rgb = SHIP_RGB;
    else if (star_lit(x_p1, y_p1, scroll))        pix_rgb = STAR_RGB;
  end

  // Stage 2: colour and delayed syncs, aligned to each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_p2 <= '0;
      hs_p2  <= 1'b0;
      vs_p2  <= 1'b0;
    end else if (tick) begin
      rgb_p2 <= pix_rgb;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_tick_r <= 1'b0;
      scroll       <= '0;
    end else begin
      frame_tick_r <= boundary;
      if (boundary) scroll <= scroll + 10'd1;
    end
  end

  // A pending position only reaches the active registers at a frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      pend_x  <= '0;
      pend_y  <= '0;
      ship_x  <= SHIP_X_RST;
      ship_y  <= SHIP_Y_RST;
    end else if (boundary && pending) begin
      ship_x  <= pend_x;
      ship_y  <= pend_y;
      pending <= 1'b0;
    end else if (accept) begin
      pend_x  <= sat_pos(pos_x, X_MAX);
      pend_y  <= sat_pos(pos_y, Y_MAX);
      pending <= 1'b1;
    end
  end

  assign pos_ready  = ~pending;
  assign rgb        = rgb_p2;
  assign hsync_out  = hs_p2;
  assign vsync_out  = vs_p2;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_star_pixel_gen.sv
// Bench for star_pixel_gen: fixed vector table, directed multi-tick sequences and
// randomized traffic compared against a coordinate-level reference model.
module tb_star_pixel_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_clock;
  logic [9:0]  x, y, pos_x, pos_y;
  logic        video_on, hsync, vsync, pos_valid;
  logic        pos_ready, hsync_out, vsync_out, frame_tick;
  logic [11:0] rgb;

  star_pixel_gen dut (
    .clk(clk), .reset(reset), .p_clock(p_clock), .x(x), .y(y),
    .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the screen should look like, in plain integers.
  int m_scroll, m_sx, m_sy, m_qx, m_qy;
  bit m_pend;
  int pv_x, pv_y;
  bit pv_von, pv_hs, pv_vs;

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic        von;
    logic [11:0] exp;
  } vec_t;
  vec_t tbl[12];

  function automatic int ref_rgb(int sx, int sy, bit von);
    int dx, dy, ry;
    if (!von) return 0;
    dx = sx - m_sx;
    dy = sy - m_sy;
    if (dx >= 0 && dx < 16 && dy >= 0 && dy < 16 && dx >= 7 - dy / 2 && dx <= 8 + dy / 2)
      return 'hFF0;
    ry = (sy - m_scroll + 1024) % 1024;
    if ((((sx % 32) ^ (ry % 32)) == 21) && (((sx / 32) % 2) == ((ry / 64) % 2)))
      return 'hFFF;
    return 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    p_clock = 1'b0; x = '0; y = '0; video_on = 1'b0; hsync = 1'b0; vsync = 1'b0;
    pos_x = '0; pos_y = '0; pos_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_scroll = 0; m_sx = 312; m_sy = 440; m_pend = 0; m_qx = 0; m_qy = 0;
    pv_x = 0; pv_y = 0; pv_von = 0; pv_hs = 0; pv_vs = 0;
    #1;
    check("reset_rgb", int'(rgb), 0);
    check("reset_pos_ready", int'(pos_ready), 1);
    check("reset_frame_tick", int'(frame_tick), 0);
    check("reset_hsync_out", int'(hsync_out), 0);
  endtask

  // One pixel period: rising p_clock, four clk cycles, outputs checked after the tick.
  task automatic pix(input logic [9:0] px, input logic [9:0] py,
                     input logic von, input logic hs, input logic vs);
    int exp;
    bit bnd;
    @(negedge clk);
    x = px; y = py; video_on = von; hsync = hs; vsync = vs;
    p_clock = 1'b1;
    @(posedge clk);
    #1;
    exp = ref_rgb(pv_x, pv_y, pv_von);
    bnd = vs && !pv_vs;
    check("rgb", int'(rgb), exp);
    check("hsync_out", int'(hsync_out), int'(pv_hs));
    check("vsync_out", int'(vsync_out), int'(pv_vs));
    check("frame_tick", int'(frame_tick), int'(bnd));
    if (bnd) begin
      m_scroll = (m_scroll + 1) % 1024;
      if (m_pend) begin
        m_sx = m_qx; m_sy = m_qy; m_pend = 0;
      end
    end
    pv_x = int'(px); pv_y = int'(py); pv_von = von; pv_hs = hs; pv_vs = vs;
    check("pos_ready", int'(pos_ready), int'(!m_pend));
    @(posedge clk);
    #1;
    if (bnd) check("frame_tick_width", int'(frame_tick), 0);
    @(negedge clk);
    p_clock = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic send_pos(input logic [9:0] px, input logic [9:0] py);
    @(negedge clk);
    pos_x = px; pos_y = py; pos_valid = 1'b1;
    @(posedge clk);
    if (!m_pend) begin
      m_pend = 1;
      m_qx = (int'(px) > 624) ? 624 : int'(px);
      m_qy = (int'(py) > 464) ? 464 : int'(py);
    end
    #1;
    check("accept_ready", int'(pos_ready), int'(!m_pend));
    @(negedge clk);
    pos_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    p_clock = 1'b0; x = '0; y = '0; video_on = 1'b0; hsync = 1'b0; vsync = 1'b0;
    pos_x = '0; pos_y = '0; pos_valid = 1'b0;

    tbl[0]  = '{10'd319, 10'd440, 1'b1, 12'hFF0};
    tbl[1]  = '{10'd320, 10'd440, 1'b1, 12'hFF0};
    tbl[2]  = '{10'd318, 10'd440, 1'b1, 12'h000};
    tbl[3]  = '{10'd312, 10'd455, 1'b1, 12'hFF0};
    tbl[4]  = '{10'd327, 10'd455, 1'b1, 12'hFF0};
    tbl[5]  = '{10'd312, 10'd440, 1'b1, 12'h000};
    tbl[6]  = '{10'd21,  10'd0,   1'b1, 12'hFFF};
    tbl[7]  = '{10'd21,  10'd0,   1'b0, 12'h000};
    tbl[8]  = '{10'd319, 10'd440, 1'b0, 12'h000};
    tbl[9]  = '{10'd328, 10'd455, 1'b1, 12'h000};
    tbl[10] = '{10'd21,  10'd64,  1'b1, 12'h000};
    tbl[11] = '{10'd53,  10'd64,  1'b1, 12'hFFF};

    do_reset();
    foreach (tbl[i]) begin
      pix(tbl[i].px, tbl[i].py, tbl[i].von, 1'b0, 1'b0);
      pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      check($sformatf("table_%0d", i), int'(rgb), int'(tbl[i].exp));
    end

    // Sync latency: hsync presented at tick N emerges after tick N+1.
    pix(10'd5, 10'd5, 1'b0, 1'b1, 1'b0);
    check("hsync_lat_early", int'(hsync_out), 0);
    pix(10'd5, 10'd5, 1'b0, 1'b0, 1'b0);
    check("hsync_lat", int'(hsync_out), 1);

    // Deferred move: old position persists until the vsync rising edge.
    send_pos(10'd100, 10'd200);
    check("ready_drop", int'(pos_ready), 0);
    send_pos(10'd0, 10'd0);
    pix(10'd107, 10'd200, 1'b1, 1'b0, 1'b0);
    pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    check("deferred_old", int'(rgb), 0);
    pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("ready_back", int'(pos_ready), 1);
    pix(10'd107, 10'd200, 1'b1, 1'b0, 1'b1);
    pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("moved_apex", int'(rgb), 'hFF0);

    // Clamp to the bottom-right corner.
    pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    send_pos(10'd700, 10'd479);
    pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    pix(10'd631, 10'd464, 1'b1, 1'b0, 1'b1);
    pix(10'd639, 10'd479, 1'b1, 1'b0, 1'b1);
    check("clamp_apex", int'(rgb), 'hFF0);
    pix(10'd624, 10'd479, 1'b1, 1'b0, 1'b1);
    check("clamp_corner", int'(rgb), 'hFF0);
    pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("clamp_left", int'(rgb), 'hFF0);

    // Starfield scrolls one row per frame.
    do_reset();
    pix(10'd21, 10'd0, 1'b1, 1'b0, 1'b0);
    pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("star_s0", int'(rgb), 'hFFF);
    pix(10'd21, 10'd1, 1'b1, 1'b0, 1'b1);
    pix(10'd21, 10'd0, 1'b1, 1'b0, 1'b1);
    check("star_s1_moved", int'(rgb), 'hFFF);
    pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("star_s1_old", int'(rgb), 0);

    // Reset during a pending request discards it.
    send_pos(10'd50, 10'd60);
    do_reset();
    pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    pix(10'd319, 10'd440, 1'b1, 1'b0, 1'b1);
    pix(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
    check("reset_drops_pending", int'(rgb), 'hFF0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic [9:0] rx, ry;
      logic rv, rh, rs;
      if ($urandom_range(0, 7) == 0)
        send_pos(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      if ($urandom_range(0, 1) == 0) begin
        rx = 10'((m_sx + int'($urandom_range(0, 19)) - 2) & 1023);
        ry = 10'((m_sy + int'($urandom_range(0, 19)) - 2) & 1023);
      end else begin
        rx = 10'($urandom_range(0, 1023));
        ry = 10'($urandom_range(0, 1023));
      end
      rv = ($urandom_range(0, 4) != 0);
      rh = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 9) == 0) ? !pv_vs : pv_vs;
      pix(rx, ry, rv, rh, rs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
